// File: rtl/iir_pkg.sv
// Shared types and arithmetic helpers for the time-multiplexed IIR filter.
package iir_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MAC_B = 3'd1,
    MAC_A = 3'd2,
    SAT   = 3'd3,
    HOLD  = 3'd4
  } state_t;

  // Coefficient map: b taps first, a taps directly after them.
  localparam int B_BASE = 0;

  function automatic int a_base(input int order);
    return order + 1;
  endfunction

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Half-up rounding by 2^frac, then clamp to a dout_w-bit signed range.
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                   input int frac, input int dout_w);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r  = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
    hi = (64'sd1 <<< (dout_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dout_w - 1));
    if (r > hi) begin
      return hi;
    end else if (r < lo) begin
      return lo;
    end else begin
      return r;
    end
  endfunction

endpackage

// File: rtl/iir_filter_tdm_mac.sv
// Shared signed multiplier feeding a clear/add/subtract accumulator.
module iir_mac #(
  parameter int COEF_W = 10,
  parameter int OPND_W = 18,
  parameter int ACC_W  = 36
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     add,
  input  logic                     sub,
  input  logic signed [COEF_W-1:0] coef,
  input  logic signed [OPND_W-1:0] opnd,
  output logic signed [ACC_W-1:0]  acc
);

  localparam int PROD_W = COEF_W + OPND_W;

  logic signed [PROD_W-1:0] prod_s;
  logic signed [ACC_W-1:0]  prod_ext_s;

  assign prod_s     = coef * opnd;
  assign prod_ext_s = {{(ACC_W - PROD_W){prod_s[PROD_W-1]}}, prod_s};

  // Accumulator: clear has priority, then add (b taps) or subtract (a taps).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (add) begin
      acc <= acc + prod_ext_s;
    end else if (sub) begin
      acc <= acc - prod_ext_s;
    end else begin
      acc <= acc;
    end
  end

endmodule

// File: rtl/iir_filter_tdm.sv
// Direct-form-I IIR filter sharing one MAC across all taps, one sample in flight.
module iir_filter_tdm
  import iir_pkg::*;
#(
  parameter int ORDER     = 16,
  parameter int DIN_W     = 8,
  parameter int COEF_W    = 10,
  parameter int COEF_FRAC = 8,
  parameter int DOUT_W    = 18,
  parameter int ACC_W     = 36,
  parameter int ADDR_W    = clog2(2 * ORDER + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DIN_W-1:0]  data_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DOUT_W-1:0] data_out,
  input  logic                     clr,
  input  logic                     coef_we,
  input  logic [ADDR_W-1:0]        coef_addr,
  input  logic signed [COEF_W-1:0] coef_wdata,
  output logic                     coef_ready
);

  localparam int NCOEF  = 2 * ORDER + 1;
  localparam int A_BASE = a_base(ORDER);
  localparam logic signed [COEF_W-1:0] COEF_ONE = {{(COEF_W-1){1'b0}}, 1'b1} << COEF_FRAC;

  state_t                    state_r;
  logic [ADDR_W-1:0]         cnt_r;
  logic signed [DIN_W-1:0]   x_hist_r [0:ORDER];
  logic signed [DOUT_W-1:0]  y_hist_r [1:ORDER];
  logic signed [COEF_W-1:0]  coef_r   [0:NCOEF-1];
  logic signed [ACC_W-1:0]   acc_s;
  logic signed [COEF_W-1:0]  coef_sel_s;
  logic signed [DOUT_W-1:0]  opnd_sel_s;
  logic signed [DOUT_W-1:0]  sat_s;
  logic                      idle_s;
  logic                      accept_s;

  assign idle_s     = (state_r == IDLE);
  assign in_ready   = rst && idle_s && !clr;
  assign coef_ready = idle_s;
  assign accept_s   = in_valid && in_ready;
  assign sat_s      = DOUT_W'(round_sat({{(64 - ACC_W){acc_s[ACC_W-1]}}, acc_s}, COEF_FRAC, DOUT_W));

  // cnt_r doubles as the coefficient address; x index in MAC_B, y index minus ORDER in MAC_A.
  always_comb begin
    coef_sel_s = '0;
    opnd_sel_s = '0;
    for (int i = 0; i < NCOEF; i++) begin
      coef_sel_s = (cnt_r == ADDR_W'(i)) ? coef_r[i] : coef_sel_s;
    end
    if (state_r == MAC_B) begin
      for (int i = 0; i <= ORDER; i++) begin
        opnd_sel_s = (cnt_r == ADDR_W'(i)) ?
                     {{(DOUT_W - DIN_W){x_hist_r[i][DIN_W-1]}}, x_hist_r[i]} : opnd_sel_s;
      end
    end else begin
      for (int i = 1; i <= ORDER; i++) begin
        opnd_sel_s = (cnt_r == ADDR_W'(A_BASE + i - 1)) ? y_hist_r[i] : opnd_sel_s;
      end
    end
  end

  iir_mac #(
    .COEF_W (COEF_W),
    .OPND_W (DOUT_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept_s),
    .add  (state_r == MAC_B),
    .sub  (state_r == MAC_A),
    .coef (coef_sel_s),
    .opnd (opnd_sel_s),
    .acc  (acc_s)
  );

  // Sequencer with registered output handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      out_valid <= 1'b0;
      data_out  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            cnt_r   <= '0;
            state_r <= MAC_B;
          end
        end
        MAC_B: begin
          if (cnt_r == ADDR_W'(ORDER)) state_r <= MAC_A;
          cnt_r <= cnt_r + 1'b1;
        end
        MAC_A: begin
          if (cnt_r == ADDR_W'(2 * ORDER)) begin
            state_r <= SAT;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        SAT: begin
          data_out  <= sat_s;
          out_valid <= 1'b1;
          state_r   <= HOLD;
        end
        HOLD: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  // Sample histories: shift x on accept, flush on clr while idle, shift y on result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i <= ORDER; i++) x_hist_r[i] <= '0;
      for (int i = 1; i <= ORDER; i++) y_hist_r[i] <= '0;
    end else if (accept_s) begin
      x_hist_r[0] <= data_in;
      for (int i = 1; i <= ORDER; i++) x_hist_r[i] <= x_hist_r[i-1];
    end else if (idle_s && clr) begin
      for (int i = 0; i <= ORDER; i++) x_hist_r[i] <= '0;
      for (int i = 1; i <= ORDER; i++) y_hist_r[i] <= '0;
    end else if (state_r == SAT) begin
      y_hist_r[1] <= sat_s;
      for (int i = 2; i <= ORDER; i++) y_hist_r[i] <= y_hist_r[i-1];
    end
  end

  // Coefficient file, reset to an identity filter; writes only land while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCOEF; i++) coef_r[i] <= (i == B_BASE) ? COEF_ONE : '0;
    end else if (coef_we && idle_s) begin
      for (int i = 0; i < NCOEF; i++) begin
        if (coef_addr == ADDR_W'(i)) coef_r[i] <= coef_wdata;
      end
    end
  end

endmodule

// File: tb/tb_iir_filter_tdm.sv
// Directed test of iir_filter_tdm at default parameters with hand-computed expectations.
module tb_iir_filter_tdm;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [7:0]  data_in;
  logic               out_valid;
  logic               out_ready;
  logic signed [17:0] data_out;
  logic               clr;
  logic               coef_we;
  logic [5:0]         coef_addr;
  logic signed [9:0]  coef_wdata;
  logic               coef_ready;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  iir_filter_tdm dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_in    (data_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .data_out   (data_out),
    .clr        (clr),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .coef_ready (coef_ready)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input int addr, input int val);
    coef_we    = 1'b1;
    coef_addr  = 6'(addr);
    coef_wdata = 10'(val);
    @(posedge clk);
    #1 coef_we = 1'b0;
  endtask

  // Present one sample, count edges to out_valid (bounded), acknowledge if out_ready is high.
  task automatic send(input int x, output longint y, output int lat);
    data_in  = 8'(x);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    y = data_out;
    if (out_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_check(input string tag, input int x, input longint exp);
    longint y;
    int     lat;
    send(x, y, lat);
    check({tag, "_data"}, y, exp);
    check({tag, "_latency"}, lat, 34);
  endtask

  initial begin
    longint y;
    int     lat;
    longint m;
    logic   seen;
    int     fir_exp [5] = '{64, 0, -32, 0, 0};
    int     fb_exp  [9] = '{64, 32, 16, 8, 4, 2, 1, 1, 1};

    rst = 1'b0; in_valid = 1'b0; data_in = 8'sd0; out_ready = 1'b1; clr = 1'b0;
    coef_we = 1'b0; coef_addr = 6'd0; coef_wdata = 10'sd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_data_out", data_out, 0);
    check("reset_in_ready", in_ready, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("idle_in_ready", in_ready, 1);
    check("idle_coef_ready", coef_ready, 1);

    send_check("ident_5", 5, 5);
    send_check("ident_m128", -128, -128);
    send_check("ident_127", 127, 127);

    // b0 = 1.0, b2 = -0.5
    do_reset();
    write_coef(2, -128);
    for (int i = 0; i < 5; i++) send_check("fir", (i == 0) ? 64 : 0, fir_exp[i]);

    // a1 = -0.5: y = x + y/2 with half-up rounding settling at 1
    do_reset();
    write_coef(17, -128);
    for (int i = 0; i < 9; i++) send_check("feedback", (i == 0) ? 64 : 0, fb_exp[i]);

    // a1 = -2.0: y = x + 2y, quickly driven into the rails
    do_reset();
    write_coef(17, -512);
    m = 0;
    for (int i = 0; i < 13; i++) begin
      m = 127 + 2 * m;
      if (m > 131071) m = 131071;
      send_check("sat_pos", 127, m);
    end
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    m = 0;
    for (int i = 0; i < 13; i++) begin
      m = -128 + 2 * m;
      if (m < -131072) m = -131072;
      send_check("sat_neg", -128, m);
    end

    // Output back-pressure with a coefficient write attempted while busy
    do_reset();
    out_ready = 1'b0;
    send(7, y, lat);
    check("hs_first_data", y, 7);
    check("hs_first_latency", lat, 34);
    for (int i = 0; i < 10; i++) begin
      coef_we    = (i == 3);
      coef_addr  = 6'd0;
      coef_wdata = 10'sd128;
      @(posedge clk);
      #1;
      check("hs_hold_data", data_out, 7);
      check("hs_hold_valid", out_valid, 1);
      check("hs_in_ready", in_ready, 0);
    end
    coef_we   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("hs_release_valid", out_valid, 0);
    check("hs_release_in_ready", in_ready, 1);
    send_check("hs_dropped_write", 3, 3);

    // clr beats in_valid; with b1 = 1.0 a surviving x history would show up
    write_coef(1, 256);
    clr      = 1'b1;
    in_valid = 1'b1;
    data_in  = 8'sd50;
    #1;
    check("clr_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    check("clr_still_idle", coef_ready, 1);
    send_check("clr_history", 10, 10);

    // Reset during MAC_A aborts the sample and restores identity coefficients
    write_coef(0, 511);
    data_in  = 8'sd20;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (25) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_valid", seen, 0);
    send_check("midrst_identity", 9, 9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
